// File: rtl/uart_sram_bridge.sv
// UART command bridge to a 16-bit SRAM controller: 'W' a a d d writes, 'R' a a reads,
// replying with ACK, two read-data bytes, or NAK on bad opcode / memory timeout.
module uart_sram_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter logic [7:0]  ACK_BYTE       = 8'h4B,
  parameter logic [7:0]  NAK_BYTE       = 8'h3F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_wr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  input  logic        mem_busy,
  output logic        cmd_active
);

  localparam int unsigned   TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    OP_WRITE = 8'h57;
  localparam logic [7:0]    OP_READ  = 8'h52;

  typedef enum logic [2:0] {
    IDLE, ARGS, MEM_REQ, MEM_WAIT, TX_SEND, TX_GAP, TX_WAIT
  } state_t;

  state_t        state, state_n;
  logic          is_write;
  logic [2:0]    arg_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [15:0]   resp_q;
  logic [1:0]    resp_cnt;

  // Handshake: rx_valid is a one-cycle strobe taken only in IDLE/ARGS; mem_wr/mem_rd and
  // tx_send are one-cycle registered pulses issued only when the matching busy input was low.
  logic take_op, take_arg, issue, mem_done, mem_tmo, tx_fire, cnt_run;
  logic op_valid, arg_last, tmo_last, wr_settled;

  assign op_valid   = (rx_data == OP_WRITE) || (rx_data == OP_READ);
  assign arg_last   = is_write ? (arg_cnt == 3'd3) : (arg_cnt == 3'd1);
  assign tmo_last   = (tmo_cnt == TMO_LAST);
  assign wr_settled = (tmo_cnt >= TW'(2));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (take_op) state_n = op_valid ? ARGS : TX_SEND;
      ARGS: begin
        if (take_arg) begin
          if (arg_last) state_n = MEM_REQ;
        end else if (tmo_last) begin
          state_n = IDLE;
        end
      end
      MEM_REQ:  if (issue) state_n = MEM_WAIT;
      MEM_WAIT: if (mem_done || mem_tmo) state_n = TX_SEND;
      TX_SEND:  if (tx_fire) state_n = TX_GAP;
      TX_GAP:   state_n = TX_WAIT;
      TX_WAIT:  if (!tx_busy) state_n = (resp_cnt != 2'd0) ? TX_SEND : IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    cmd_active = (state != IDLE);
    take_op    = 1'b0;
    take_arg   = 1'b0;
    issue      = 1'b0;
    mem_done   = 1'b0;
    mem_tmo    = 1'b0;
    tx_fire    = 1'b0;
    cnt_run    = 1'b0;
    case (state)
      IDLE:     take_op = rx_valid;
      ARGS: begin
        take_arg = rx_valid;
        cnt_run  = !rx_valid && !tmo_last;
      end
      MEM_REQ:  issue = !mem_busy;
      MEM_WAIT: begin
        // A write is only trusted once busy has had two cycles to rise after the pulse.
        mem_done = is_write ? (wr_settled && !mem_busy) : mem_valid;
        mem_tmo  = !mem_done && tmo_last;
        cnt_run  = !mem_done && !tmo_last;
      end
      TX_SEND:  tx_fire = !tx_busy;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data   <= 8'h00;
      tx_send   <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 16'h0000;
      mem_wr    <= 1'b0;
      mem_rd    <= 1'b0;
      is_write  <= 1'b0;
      arg_cnt   <= 3'd0;
      tmo_cnt   <= '0;
      resp_q    <= 16'h0000;
      resp_cnt  <= 2'd0;
    end else begin
      mem_wr  <= 1'b0;
      mem_rd  <= 1'b0;
      tx_send <= 1'b0;
      if (cnt_run) tmo_cnt <= tmo_cnt + TW'(1);
      if (take_op) begin
        is_write <= (rx_data == OP_WRITE);
        arg_cnt  <= 3'd0;
        tmo_cnt  <= '0;
        if (!op_valid) begin
          resp_q   <= {NAK_BYTE, 8'h00};
          resp_cnt <= 2'd1;
        end
      end
      if (take_arg) begin
        case (arg_cnt)
          3'd0:    mem_addr[15:8]  <= rx_data;
          3'd1:    mem_addr[7:0]   <= rx_data;
          3'd2:    mem_wdata[15:8] <= rx_data;
          default: mem_wdata[7:0]  <= rx_data;
        endcase
        arg_cnt <= arg_cnt + 3'd1;
        tmo_cnt <= '0;
      end
      if (issue) begin
        mem_wr  <= is_write;
        mem_rd  <= !is_write;
        tmo_cnt <= '0;
      end
      if (mem_done) begin
        if (is_write) begin
          resp_q   <= {ACK_BYTE, 8'h00};
          resp_cnt <= 2'd1;
        end else begin
          resp_q   <= mem_rdata;
          resp_cnt <= 2'd2;
        end
      end else if (mem_tmo) begin
        resp_q   <= {NAK_BYTE, 8'h00};
        resp_cnt <= 2'd1;
      end
      // Response bytes leave MSB first; tx_data then holds until the next send.
      if (tx_fire) begin
        tx_data  <= resp_q[15:8];
        tx_send  <= 1'b1;
        resp_q   <= {resp_q[7:0], 8'h00};
        resp_cnt <= resp_cnt - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_sram_bridge.sv
// Bench for uart_sram_bridge: reactive SRAM and UART models, a command-level reference
// model building expected request/response queues, and directed plus random commands.
module tb_uart_sram_bridge;

  localparam int         TMO = 16;
  localparam logic [7:0] ACK = 8'h4B;
  localparam logic [7:0] NAK = 8'h3F;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy = 1'b0;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_wr;
  logic        mem_rd;
  logic [15:0] mem_rdata = 16'h0000;
  logic        mem_valid = 1'b0;
  logic        mem_busy = 1'b0;
  logic        cmd_active;

  uart_sram_bridge #(.TIMEOUT_CYCLES(TMO), .ACK_BYTE(ACK), .NAK_BYTE(NAK)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_valid(mem_valid), .mem_busy(mem_busy),
    .cmd_active(cmd_active)
  );

  // Clock and cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500_000;
    $display("FAIL watchdog: observed no end of test, required end before 50000 cycles");
    $fatal(1, "watchdog");
  end

  // Environment knobs, owned by the stimulus block
  int stall_until = 0;
  bit rd_respond  = 1'b1;
  int wr_busy_max = 3;
  int tx_dur_max  = 4;

  // Observed traffic and protocol error counts
  logic [33:0] obs_mem[$];
  int          obs_mem_cyc[$];
  logic [7:0]  obs_tx[$];
  int          obs_tx_cyc[$];
  int both_err = 0, busy_issue_err = 0, tx_overlap_err = 0, stab_err = 0;
  logic busy_at_edge = 1'b0;
  always @(posedge clk) busy_at_edge <= mem_busy;

  // SRAM controller model
  logic [15:0] sram [logic [15:0]];
  int          wr_busy_cnt = 0;
  int          rd_wait = 0;
  bit          rd_pend = 1'b0;
  logic [15:0] rd_addr = 16'h0000;
  always @(negedge clk) begin
    mem_valid = 1'b0;
    mem_rdata = 16'($urandom);
    if (wr_busy_cnt > 0) wr_busy_cnt--;
    if (mem_wr && mem_rd) both_err++;
    if ((mem_wr || mem_rd) && busy_at_edge) busy_issue_err++;
    if (mem_wr) begin
      obs_mem.push_back({2'b10, mem_addr, mem_wdata});
      obs_mem_cyc.push_back(cyc);
      sram[mem_addr] = mem_wdata;
      wr_busy_cnt = $urandom_range(0, wr_busy_max);
    end
    if (mem_rd) begin
      obs_mem.push_back({2'b01, mem_addr, 16'h0000});
      obs_mem_cyc.push_back(cyc);
      if (rd_respond) begin
        rd_pend = 1'b1;
        rd_wait = $urandom_range(0, 3);
        rd_addr = mem_addr;
      end
    end else if (rd_pend) begin
      if (rd_wait == 0) begin
        mem_valid = 1'b1;
        mem_rdata = sram.exists(rd_addr) ? sram[rd_addr] : (rd_addr ^ 16'hC35A);
        rd_pend   = 1'b0;
      end else begin
        rd_wait--;
      end
    end
    if (rst) begin
      rd_pend     = 1'b0;
      wr_busy_cnt = 0;
    end
    mem_busy = (wr_busy_cnt > 0) || (cyc < stall_until);
  end

  // UART transmitter model
  int         tx_cnt = 0;
  logic [7:0] last_tx = 8'h00;
  always @(negedge clk) begin
    if (tx_send) begin
      if (tx_busy) tx_overlap_err++;
      obs_tx.push_back(tx_data);
      obs_tx_cyc.push_back(cyc);
      last_tx = tx_data;
    end else if (tx_data !== last_tx) begin
      stab_err++;
    end
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_busy = 1'b0;
    end
    if (tx_send) begin
      tx_busy = 1'b1;
      tx_cnt  = $urandom_range(1, tx_dur_max);
    end
    if (rst) last_tx = 8'h00;
  end

  // Scoreboard
  int n_assert = 0;
  int n_fail   = 0;
  logic [33:0] exp_mem[$];
  logic [7:0]  exp_q[$];
  logic [15:0] ref_mem [logic [15:0]];
  int mem_idx = 0;
  int tx_idx  = 0;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_val(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ 16'hC35A);
  endfunction

  task automatic compare(input string tag);
    check({tag, "_mem_count"}, 34'(obs_mem.size() - mem_idx), 34'(exp_mem.size()));
    for (int i = 0; i < exp_mem.size(); i++)
      if (mem_idx + i < obs_mem.size())
        check({tag, "_mem_op"}, obs_mem[mem_idx + i], exp_mem[i]);
    check({tag, "_tx_count"}, 34'(obs_tx.size() - tx_idx), 34'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (tx_idx + i < obs_tx.size())
        check({tag, "_tx_byte"}, 34'(obs_tx[tx_idx + i]), 34'(exp_q[i]));
    mem_idx = obs_mem.size();
    tx_idx  = obs_tx.size();
    exp_mem.delete();
    exp_q.delete();
  endtask

  // Drivers
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap_max);
    send_byte(b);
    idle($urandom_range(0, gap_max));
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d, input int gap_max);
    send_gap(8'h57, gap_max);
    send_gap(a[15:8], gap_max);
    send_gap(a[7:0], gap_max);
    send_gap(d[15:8], gap_max);
    send_byte(d[7:0]);
    exp_mem.push_back({2'b10, a, d});
    ref_mem[a] = d;
    exp_q.push_back(ACK);
  endtask

  task automatic do_read(input logic [15:0] a, input int gap_max);
    logic [15:0] v;
    send_gap(8'h52, gap_max);
    send_gap(a[15:8], gap_max);
    send_byte(a[7:0]);
    v = ref_val(a);
    exp_mem.push_back({2'b01, a, 16'h0000});
    exp_q.push_back(v[15:8]);
    exp_q.push_back(v[7:0]);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (cmd_active === 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_back_to_idle"}, 34'(cmd_active), 34'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_mem_op(input string tag);
    int k;
    k = 0;
    while (obs_mem.size() <= mem_idx && k < 100) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_req_seen"}, 34'(obs_mem.size() > mem_idx), 34'(1));
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_tx_data"}, 34'(tx_data), 34'(0));
    check({tag, "_tx_send"}, 34'(tx_send), 34'(0));
    check({tag, "_mem_addr"}, 34'(mem_addr), 34'(0));
    check({tag, "_mem_wdata"}, 34'(mem_wdata), 34'(0));
    check({tag, "_mem_wr"}, 34'(mem_wr), 34'(0));
    check({tag, "_mem_rd"}, 34'(mem_rd), 34'(0));
    check({tag, "_cmd_active"}, 34'(cmd_active), 34'(0));
  endtask

  initial begin
    logic [7:0]  op;
    logic [15:0] a;
    int          delta;

    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(2);

    do_write(16'hFF11, 16'hFFAA, 0);
    wait_idle("write");
    compare("write");

    do_read(16'hFF11, 0);
    wait_idle("read");
    compare("read");

    send_byte(8'h41);
    exp_q.push_back(NAK);
    wait_idle("bad_op");
    compare("bad_op");
    do_read(16'h0001, 0);
    wait_idle("after_bad");
    compare("after_bad");

    // Partial command abandoned by the inter-byte timeout
    send_byte(8'h57);
    send_byte(8'h12);
    idle(TMO + 4);
    @(negedge clk);
    check("args_timeout_idle", 34'(cmd_active), 34'(0));
    compare("args_timeout");
    idle(1);
    do_read(16'h0000, 0);
    wait_idle("after_tmo");
    compare("after_tmo");

    // Gaps shorter than the timeout keep the command alive
    send_byte(8'h52);
    idle(12);
    send_byte(8'h00);
    idle(12);
    send_byte(8'h05);
    exp_mem.push_back({2'b01, 16'h0005, 16'h0000});
    a = ref_val(16'h0005);
    exp_q.push_back(a[15:8]);
    exp_q.push_back(a[7:0]);
    wait_idle("slow_args");
    compare("slow_args");

    // Write with a controller that never raises busy: ACK still waits the settle window
    wr_busy_max = 0;
    do_write(16'h0020, 16'h1234, 0);
    wait_idle("wr_nobusy");
    delta = obs_tx_cyc[obs_tx_cyc.size() - 1] - obs_mem_cyc[obs_mem_cyc.size() - 1];
    check("wr_ack_delay_min3", 34'(delta >= 3), 34'(1));
    compare("wr_nobusy");
    wr_busy_max = 3;

    // Busy stall at MEM_REQ, bytes dropped in MEM_WAIT, read never answered
    rd_respond = 1'b0;
    send_byte(8'h52);
    send_byte(8'h00);
    stall_until = cyc + 11;
    send_byte(8'h40);
    wait_mem_op("stall");
    check("stall_issue_after_busy", 34'(obs_mem_cyc[obs_mem_cyc.size() - 1] >= stall_until), 34'(1));
    send_byte(8'h57);
    send_byte(8'h52);
    send_byte(8'h41);
    exp_mem.push_back({2'b01, 16'h0040, 16'h0000});
    exp_q.push_back(NAK);
    wait_idle("stall");
    delta = obs_tx_cyc[obs_tx_cyc.size() - 1] - obs_mem_cyc[obs_mem_cyc.size() - 1];
    check("mem_timeout_delay", 34'(delta >= TMO), 34'(1));
    compare("stall");

    // Reset while waiting for read data
    send_byte(8'h52);
    send_byte(8'h12);
    send_byte(8'h34);
    wait_mem_op("mid_rst");
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_rst");
    exp_mem.push_back({2'b01, 16'h1234, 16'h0000});
    idle(30);
    compare("mid_rst");
    rd_respond = 1'b1;
    do_read(16'h1234, 0);
    wait_idle("after_rst");
    compare("after_rst");

    // Random commands against the reference model
    wr_busy_max = 4;
    tx_dur_max  = 6;
    for (int n = 0; n < 16; n++) begin
      a = 16'h0100 + 16'($urandom_range(0, 3));
      case ($urandom_range(0, 2))
        0: do_write(a, 16'($urandom), 3);
        1: do_read(a, 3);
        default: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
          send_byte(op);
          exp_q.push_back(NAK);
        end
      endcase
      wait_idle("rnd");
      compare("rnd");
      idle($urandom_range(0, 4));
    end

    check("no_wr_rd_overlap", 34'(both_err), 34'(0));
    check("no_req_while_busy", 34'(busy_issue_err), 34'(0));
    check("no_send_while_tx_busy", 34'(tx_overlap_err), 34'(0));
    check("tx_data_stable", 34'(stab_err), 34'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
